// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg
//   Shared types for the tile scheduler slice.
//   - sched_state_t : scheduler FSM states
//   - LT_*          : layer-type codes carried on layer_type_i
//   - tile_cmd_t    : one tile command (indices, clipped lengths, rows, psum flags)
//   Command field widths match the scheduler's default CH_W/ROW_W parameters.
package tile_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

    localparam logic [1:0] LT_PW  = 2'd0;
    localparam logic [1:0] LT_DW  = 2'd1;
    localparam logic [1:0] LT_STD = 2'd2;
    localparam logic [1:0] LT_LIN = 2'd3;

    localparam int unsigned CMD_CH_W  = 11;
    localparam int unsigned CMD_ROW_W = 8;
    localparam int unsigned CMD_LEN_W = 8;

    typedef struct packed {
        logic [CMD_CH_W-1:0]  k_idx;
        logic [CMD_CH_W-1:0]  d_idx;
        logic [CMD_LEN_W-1:0] k_len;
        logic [CMD_LEN_W-1:0] d_len;
        logic [CMD_ROW_W-1:0] row;
        logic [CMD_ROW_W-1:0] rows;
        logic                 first_d;
        logic                 last_d;
    } tile_cmd_t;

endpackage

// File: rtl/tile_scheduler_axis.sv
// tile_axis_counter
//   One tiled loop axis: walks idx = 0, step, 2*step, ... below total and
//   reports the clipped extent of the current tile.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     clear       return idx to 0 (new layer)
//     advance     step to the next tile; wraps to 0 after the last one
//     total       axis length (W bits)
//     step        tile size (LEN_W bits, LEN_W <= W)
//     idx         current tile base
//     len         min(step, total - idx)
//     last        current tile is the final one on this axis
module tile_axis_counter
    import tile_sched_pkg::*;
#(
    parameter int W     = 11,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [W-1:0]     total,
    input  logic [LEN_W-1:0] step,
    output logic [W-1:0]     idx,
    output logic [LEN_W-1:0] len,
    output logic             last
);

    // One extra bit so idx + step cannot wrap at the maximum totals.
    logic [W:0] step_ext;
    logic [W:0] remaining;
    logic [W:0] next_sum;

    assign step_ext  = {{(W + 1 - LEN_W){1'b0}}, step};
    assign remaining = {1'b0, total} - {1'b0, idx};
    assign next_sum  = {1'b0, idx} + step_ext;
    assign last      = (next_sum >= {1'b0, total});

    // remaining < step implies remaining fits in LEN_W bits.
    assign len = (remaining < step_ext) ? remaining[LEN_W-1:0] : step;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= last ? '0 : next_sum[W-1:0];
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler
//   Takes one decoded layer's tiling parameters on start_i and walks the
//   k (outer) / row (middle) / d (inner) tile loops, emitting one tile
//   command per valid/ready handshake.
//   Ports:
//     clk, rst_n                   clock, synchronous active-low reset
//     start_i                      pulse in IDLE: capture layer parameters
//     layer_type_i                 0=PW 1=DW 2=STD 3=LIN
//     in_D_i, out_K_i              input / output channel counts
//     tile_D_i, tile_K_i           channel tile sizes
//     out_R_i, tile_n_i            output rows, rows per tile
//     cmd_valid_o, cmd_ready_i     command handshake
//     cmd_k_idx_o, cmd_d_idx_o     tile base channels
//     cmd_k_len_o, cmd_d_len_o     clipped channel extents
//     cmd_row_o, cmd_rows_o        first output row, row count
//     cmd_first_d_o, cmd_last_d_o  psum init / psum writeback
//     busy_o                       high in LOAD and ISSUE
//     done_o                       one-cycle completion pulse
//     perf_stall_o, perf_cmds_o    stall / handshake counters
//   Build option: TILE_SCHED_PERF_EN enables the performance counters;
//   without it both counter ports are constant 0.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int CH_W  = 11,
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       layer_type_i,
    input  logic [CH_W-1:0]  in_D_i,
    input  logic [CH_W-1:0]  out_K_i,
    input  logic [7:0]       tile_D_i,
    input  logic [7:0]       tile_K_i,
    input  logic [ROW_W-1:0] out_R_i,
    input  logic [31:0]      tile_n_i,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [CH_W-1:0]  cmd_k_idx_o,
    output logic [CH_W-1:0]  cmd_d_idx_o,
    output logic [7:0]       cmd_k_len_o,
    output logic [7:0]       cmd_d_len_o,
    output logic [ROW_W-1:0] cmd_row_o,
    output logic [ROW_W-1:0] cmd_rows_o,
    output logic             cmd_first_d_o,
    output logic             cmd_last_d_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      perf_stall_o,
    output logic [31:0]      perf_cmds_o
);

    if (CH_W != int'(CMD_CH_W) || ROW_W != int'(CMD_ROW_W)) begin : g_width_check
        $error("tile_scheduler: CH_W/ROW_W must match tile_sched_pkg command widths");
    end

    sched_state_t state_q, state_d;

    logic [1:0]       layer_type_q;
    logic [CH_W-1:0]  in_d_q, out_k_q;
    logic [7:0]       tile_d_q, tile_k_q;
    logic [ROW_W-1:0] out_r_q;
    logic [31:0]      tile_n_q;
    logic [ROW_W-1:0] rows_per_q, rows_per_d;

    logic accept_start, fire;
    logic is_dw, needs_d, layer_empty;
    logic d_wrap, final_cmd;

    logic [CH_W-1:0]  k_idx, d_idx_raw;
    logic [7:0]       k_len, d_len_raw;
    logic             k_last, d_last_raw;
    logic [ROW_W-1:0] row_idx, row_len;
    logic             row_last;

    tile_cmd_t cmd;

    assign accept_start = (state_q == S_IDLE) && start_i;
    assign cmd_valid_o  = (state_q == S_ISSUE);
    assign fire         = cmd_valid_o && cmd_ready_i;
    assign busy_o       = (state_q == S_LOAD) || (state_q == S_ISSUE);
    assign done_o       = (state_q == S_DONE);

    assign is_dw   = (layer_type_q == LT_DW);
    assign needs_d = (layer_type_q == LT_PW) || (layer_type_q == LT_STD) ||
                     (layer_type_q == LT_LIN);

    assign layer_empty = (out_k_q == '0) || (in_d_q == '0) || (out_r_q == '0) ||
                         (tile_k_q == '0) || (needs_d && (tile_d_q == '0));

    // Parameters are captured with the accepted start so later input
    // changes (including a start pulse while busy) cannot disturb the walk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            layer_type_q <= '0;
            in_d_q       <= '0;
            out_k_q      <= '0;
            tile_d_q     <= '0;
            tile_k_q     <= '0;
            out_r_q      <= '0;
            tile_n_q     <= '0;
            rows_per_q   <= '0;
        end else begin
            if (accept_start) begin
                layer_type_q <= layer_type_i;
                in_d_q       <= in_D_i;
                out_k_q      <= out_K_i;
                tile_d_q     <= tile_D_i;
                tile_k_q     <= tile_K_i;
                out_r_q      <= out_R_i;
                tile_n_q     <= tile_n_i;
            end
            if (state_q == S_LOAD) begin
                rows_per_q <= rows_per_d;
            end
        end
    end

    // rows_per = clamp(tile_n, 1, out_R), compared at full 32-bit width.
    always_comb begin
        rows_per_d = out_r_q;
        if (tile_n_q == '0) begin
            rows_per_d = ROW_W'(1);
        end else if (tile_n_q < 32'(out_r_q)) begin
            rows_per_d = tile_n_q[ROW_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_LOAD;
            S_LOAD:  state_d = layer_empty ? S_DONE : S_ISSUE;
            S_ISSUE: if (final_cmd) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // DW collapses the d axis: every command is both the first and last d tile.
    assign d_wrap    = is_dw || d_last_raw;
    assign final_cmd = fire && d_wrap && row_last && k_last;

    tile_axis_counter #(.W(CH_W), .LEN_W(8)) u_k_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept_start),
        .advance (fire && d_wrap && row_last),
        .total   (out_k_q),
        .step    (tile_k_q),
        .idx     (k_idx),
        .len     (k_len),
        .last    (k_last)
    );

    tile_axis_counter #(.W(ROW_W), .LEN_W(ROW_W)) u_row_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept_start),
        .advance (fire && d_wrap),
        .total   (out_r_q),
        .step    (rows_per_q),
        .idx     (row_idx),
        .len     (row_len),
        .last    (row_last)
    );

    tile_axis_counter #(.W(CH_W), .LEN_W(8)) u_d_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept_start),
        .advance (fire && !is_dw),
        .total   (in_d_q),
        .step    (tile_d_q),
        .idx     (d_idx_raw),
        .len     (d_len_raw),
        .last    (d_last_raw)
    );

    always_comb begin
        cmd         = '0;
        cmd.k_idx   = k_idx;
        cmd.k_len   = k_len;
        cmd.d_idx   = is_dw ? k_idx : d_idx_raw;
        cmd.d_len   = is_dw ? k_len : d_len_raw;
        cmd.row     = row_idx;
        cmd.rows    = row_len;
        cmd.first_d = is_dw || (d_idx_raw == '0);
        cmd.last_d  = is_dw || d_last_raw;
    end

    // Payload reads as zero whenever no command is offered.
    assign cmd_k_idx_o   = cmd_valid_o ? cmd.k_idx   : '0;
    assign cmd_d_idx_o   = cmd_valid_o ? cmd.d_idx   : '0;
    assign cmd_k_len_o   = cmd_valid_o ? cmd.k_len   : '0;
    assign cmd_d_len_o   = cmd_valid_o ? cmd.d_len   : '0;
    assign cmd_row_o     = cmd_valid_o ? cmd.row     : '0;
    assign cmd_rows_o    = cmd_valid_o ? cmd.rows    : '0;
    assign cmd_first_d_o = cmd_valid_o && cmd.first_d;
    assign cmd_last_d_o  = cmd_valid_o && cmd.last_d;

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] stall_q, cmds_q;

    always_ff @(posedge clk) begin
        if (!rst_n || accept_start) begin
            stall_q <= '0;
            cmds_q  <= '0;
        end else begin
            if (cmd_valid_o && !cmd_ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (fire && (cmds_q != '1)) begin
                cmds_q <= cmds_q + 32'd1;
            end
        end
    end

    assign perf_stall_o = stall_q;
    assign perf_cmds_o  = cmds_q;
`else
    assign perf_stall_o = '0;
    assign perf_cmds_o  = '0;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler
//   Directed bench for tile_scheduler. The expected command stream of each
//   layer is generated from the loop rules (k outer, row middle, d inner)
//   into a queue; a negedge process checks every offered command against
//   the queue head and pops it on handshake.
module tb_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  layer_type_i;
    logic [10:0] in_D_i, out_K_i;
    logic [7:0]  tile_D_i, tile_K_i;
    logic [7:0]  out_R_i;
    logic [31:0] tile_n_i;
    logic        cmd_valid_o, cmd_ready_i;
    logic [10:0] cmd_k_idx_o, cmd_d_idx_o;
    logic [7:0]  cmd_k_len_o, cmd_d_len_o;
    logic [7:0]  cmd_row_o, cmd_rows_o;
    logic        cmd_first_d_o, cmd_last_d_o;
    logic        busy_o, done_o;
    logic [31:0] perf_stall_o, perf_cmds_o;

    always #5 clk = ~clk;

    tile_scheduler #(.CH_W(11), .ROW_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .layer_type_i  (layer_type_i),
        .in_D_i        (in_D_i),
        .out_K_i       (out_K_i),
        .tile_D_i      (tile_D_i),
        .tile_K_i      (tile_K_i),
        .out_R_i       (out_R_i),
        .tile_n_i      (tile_n_i),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_ready_i   (cmd_ready_i),
        .cmd_k_idx_o   (cmd_k_idx_o),
        .cmd_d_idx_o   (cmd_d_idx_o),
        .cmd_k_len_o   (cmd_k_len_o),
        .cmd_d_len_o   (cmd_d_len_o),
        .cmd_row_o     (cmd_row_o),
        .cmd_rows_o    (cmd_rows_o),
        .cmd_first_d_o (cmd_first_d_o),
        .cmd_last_d_o  (cmd_last_d_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .perf_stall_o  (perf_stall_o),
        .perf_cmds_o   (perf_cmds_o)
    );

    typedef struct {
        int k_idx, k_len, d_idx, d_len, row, rows;
        bit first_d, last_d;
    } exp_cmd_t;

    exp_cmd_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_hs     = 0;
    bit  active   = 1'b0;
    bit  expect_done = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected stream straight from the loop definition.
    task automatic build_model(input int lt, input int ind, input int outk,
                               input int td, input int tk, input int outr,
                               input longint tn);
        int rp;
        exp_cmd_t c;
        exp_q.delete();
        if (outk == 0 || ind == 0 || outr == 0 || tk == 0 || (lt != 1 && td == 0))
            return;
        rp = (tn == 0) ? 1 : ((tn > outr) ? outr : int'(tn));
        for (int k = 0; k < outk; k += tk) begin
            for (int r = 0; r < outr; r += rp) begin
                c.k_idx = k;
                c.k_len = (tk < outk - k) ? tk : outk - k;
                c.row   = r;
                c.rows  = (rp < outr - r) ? rp : outr - r;
                if (lt == 1) begin
                    c.d_idx = k; c.d_len = c.k_len; c.first_d = 1; c.last_d = 1;
                    exp_q.push_back(c);
                end else begin
                    for (int d = 0; d < ind; d += td) begin
                        c.d_idx   = d;
                        c.d_len   = (td < ind - d) ? td : ind - d;
                        c.first_d = (d == 0);
                        c.last_d  = (d + c.d_len == ind);
                        exp_q.push_back(c);
                    end
                end
            end
        end
    endtask

    // Compare process: every offered command must equal the queue head.
    always @(negedge clk) begin
        if (active && rst_n) begin
            if (expect_done) begin
                chk("done_after_last_hs", done_o, 1);
                chk("valid_drop_after_last_hs", cmd_valid_o, 0);
                expect_done = 1'b0;
            end
            if (cmd_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("extra_cmd", 1, 0);
                end else begin
                    chk("k_idx", cmd_k_idx_o, exp_q[0].k_idx);
                    chk("k_len", cmd_k_len_o, exp_q[0].k_len);
                    chk("d_idx", cmd_d_idx_o, exp_q[0].d_idx);
                    chk("d_len", cmd_d_len_o, exp_q[0].d_len);
                    chk("row",   cmd_row_o,   exp_q[0].row);
                    chk("rows",  cmd_rows_o,  exp_q[0].rows);
                    chk("first_d", cmd_first_d_o, exp_q[0].first_d);
                    chk("last_d",  cmd_last_d_o,  exp_q[0].last_d);
                    if (cmd_ready_i) begin
                        void'(exp_q.pop_front());
                        n_hs++;
                        if (exp_q.size() == 0) expect_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, cmd_valid_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_done"},  done_o, 0);
        chk({tag, "_payload"}, {cmd_k_idx_o, cmd_d_idx_o, cmd_k_len_o, cmd_d_len_o,
                                cmd_row_o, cmd_rows_o, cmd_first_d_o, cmd_last_d_o}, 0);
        chk({tag, "_perf_stall"}, perf_stall_o, 0);
        chk({tag, "_perf_cmds"},  perf_cmds_o, 0);
    endtask

    task automatic set_layer(input int lt, input int ind, input int outk, input int td,
                             input int tk, input int outr, input int tn);
        layer_type_i = 2'(lt);
        in_D_i = 11'(ind); out_K_i = 11'(outk);
        tile_D_i = 8'(td); tile_K_i = 8'(tk);
        out_R_i = 8'(outr); tile_n_i = 32'(tn);
        build_model(lt, ind, outk, td, tk, outr, 64'(tn));
    endtask

    // Runs the layer already loaded by set_layer. Ready is low for cycles
    // [stall_from, stall_from+stall_len) counted from the start cycle.
    task automatic run_layer(input string nm, input int exp_cmds, input int stall_from,
                             input int stall_len, input int exp_stall, input int abuse_cyc);
        bit done_seen = 1'b0;
        logic [10:0] saved_k;
        n_hs = 0;
        active = 1'b1;
        saved_k = out_K_i;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 200 && !done_seen; cyc++) begin
            cmd_ready_i = !(cyc >= stall_from && cyc < stall_from + stall_len);
            start_i = (cyc == abuse_cyc);
            out_K_i = (cyc == abuse_cyc) ? 11'd7 : saved_k;
            @(negedge clk);
            if (cyc == 1) begin
                chk({nm, "_lat_valid_t1"}, cmd_valid_o, 0);
                chk({nm, "_lat_busy_t1"},  busy_o, 1);
            end
            if (cyc == 2) begin
                chk({nm, "_lat_valid_t2"}, cmd_valid_o, (exp_cmds > 0) ? 1 : 0);
                chk({nm, "_lat_done_t2"},  done_o, (exp_cmds == 0) ? 1 : 0);
            end
            if (done_o) begin
                done_seen = 1'b1;
                chk({nm, "_cmd_count"}, n_hs, exp_cmds);
                chk({nm, "_queue_left"}, exp_q.size(), 0);
                chk({nm, "_busy_at_done"}, busy_o, 0);
`ifdef TILE_SCHED_PERF_EN
                chk({nm, "_perf_cmds"},  perf_cmds_o, exp_cmds);
                chk({nm, "_perf_stall"}, perf_stall_o, exp_stall);
`else
                chk({nm, "_perf_cmds"},  perf_cmds_o, 0);
                chk({nm, "_perf_stall"}, perf_stall_o, 0 * exp_stall);
`endif
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        out_K_i = saved_k;
        cmd_ready_i = 1'b1;
        if (!done_seen) chk({nm, "_done_timeout"}, 0, 1);
        @(negedge clk);
        chk({nm, "_done_pulse_len"}, done_o, 0);
        chk({nm, "_idle_valid"}, cmd_valid_o, 0);
`ifdef TILE_SCHED_PERF_EN
        chk({nm, "_perf_hold"}, perf_cmds_o, exp_cmds);
`endif
        active = 1'b0;
        expect_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; cmd_ready_i = 1'b1;
        set_layer(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // PW: 4 commands, d inner loop with psum flags
        set_layer(0, 64, 64, 32, 32, 4, 8);
        chk("model_pw_size", exp_q.size(), 4);
        chk("model_pw_c1_d_idx", exp_q[1].d_idx, 32);
        chk("model_pw_c1_flags", {exp_q[1].first_d, exp_q[1].last_d}, 2'b01);
        chk("model_pw_c2_k_idx", exp_q[2].k_idx, 32);
        run_layer("pw", 4, 1000, 0, 0, -1);

        // STD ragged k and rows
        set_layer(2, 10, 40, 10, 32, 10, 4);
        chk("model_std_size", exp_q.size(), 6);
        chk("model_std_c3_k_len", exp_q[3].k_len, 8);
        chk("model_std_c2_rows", exp_q[2].rows, 2);
        run_layer("std", 6, 1000, 0, 0, -1);

        // DW: d collapsed onto k, in tile_D=0 ignored
        set_layer(1, 25, 25, 0, 10, 3, 3);
        chk("model_dw_size", exp_q.size(), 3);
        chk("model_dw_c2_k_len", exp_q[2].k_len, 5);
        chk("model_dw_c2_d_idx", exp_q[2].d_idx, 20);
        run_layer("dw", 3, 1000, 0, 0, -1);

        // Backpressure: ready low for 5 cycles while a command is pending
        set_layer(2, 10, 40, 10, 32, 10, 4);
        run_layer("bp", 6, 3, 5, 5, -1);

        // Empty layer
        set_layer(0, 64, 0, 32, 32, 4, 8);
        chk("model_empty_size", exp_q.size(), 0);
        run_layer("empty", 0, 1000, 0, 0, -1);

        // tile_n = 0 behaves as 1
        set_layer(0, 8, 8, 8, 8, 3, 0);
        chk("model_tn0_size", exp_q.size(), 3);
        chk("model_tn0_rows", exp_q[1].rows, 1);
        run_layer("tn0", 3, 1000, 0, 0, -1);

        // start_i while busy (with altered out_K) must not disturb the walk
        set_layer(0, 64, 64, 32, 32, 4, 8);
        run_layer("start_busy", 4, 1000, 0, 0, 3);

        // Reset mid-ISSUE with a stalled command
        set_layer(0, 64, 64, 32, 32, 4, 8);
        active = 1'b1;
        cmd_ready_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pre_valid", cmd_valid_o, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        active = 1'b0;
        rst_n = 1'b1;
        cmd_ready_i = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid_issue");
        @(posedge clk); #1;

        // Recovery after reset
        set_layer(1, 25, 25, 0, 10, 3, 3);
        run_layer("post_rst_dw", 3, 1000, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
